// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle RV32IM execute block: ALU control codes,
// decode constants, M-extension op selector and FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLT    = 4'b0101;
    localparam logic [3:0] ALU_SLTU   = 4'b0110;
    localparam logic [3:0] ALU_SLL    = 4'b0111;
    localparam logic [3:0] ALU_SRL    = 4'b1000;
    localparam logic [3:0] ALU_SRA    = 4'b1001;
    localparam logic [3:0] ALU_MULDIV = 4'b1111;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } muldiv_op_t;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 engine on unsigned magnitudes: shift-add multiply or restoring
// divide, one step per cycle over XLEN cycles, sharing a 2*XLEN accumulator.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic                is_div_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [2*XLEN-1:0]   acc_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic              busy_q, busy_d, div_q, div_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, step_s;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN:0]     mul_sum_s, rem_sh_s, diff_s;

    // One iteration: multiply adds the multiplicand on a set LSB then shifts right;
    // divide shifts left and keeps the trial subtraction when it does not borrow.
    always_comb begin
        mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
        rem_sh_s  = acc_q[2*XLEN-1:XLEN-1];
        diff_s    = rem_sh_s - {1'b0, opb_q};
        if (div_q) begin
            if (!diff_s[XLEN]) begin
                step_s = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                step_s = {rem_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc_q[0]) begin
                step_s = {mul_sum_s, acc_q[XLEN-1:1]};
            end else begin
                step_s = {1'b0, acc_q[2*XLEN-1:1]};
            end
        end
    end

    // Load on start, otherwise advance while busy.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opb_d  = opb_q;
        div_d  = div_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = {CW{1'b0}};
            acc_d  = {{XLEN{1'b0}}, a_i};
            opb_d  = b_i;
            div_d  = is_div_i;
        end else if (busy_q) begin
            acc_d = step_s;
            if (cnt_q == LAST_STEP) begin
                busy_d = 1'b0;
                cnt_d  = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Engine state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= {CW{1'b0}};
            acc_q  <= {(2*XLEN){1'b0}};
            opb_q  <= {XLEN{1'b0}};
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opb_q  <= opb_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q & (cnt_q == LAST_STEP);
    assign acc_o  = step_s;

endmodule

// File: rtl/alu_decoder_mc.sv
// RV32IM execute stage: ALU control decode, single-cycle ALU, divide special cases,
// sign fix-up around the iterative engine, and the accept/complete FSM.
module alu_decoder_mc
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [6:0]      op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [1:0]      ALUOp,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [3:0]      alu_control_o,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o,
    output logic            illegal_o
);

    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [3:0]        ctrl_s;
    logic              illegal_s, iter_s, accept_s, start_s;
    logic              is_div_s, is_rem_s, a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, neg_s;
    logic              div_zero_s, div_ovf_s;
    logic [SW-1:0]     shamt_s;
    logic [XLEN-1:0]   alu_res_s, spec_res_s, a_mag_s, b_mag_s, fix_res_s;
    muldiv_op_t        md_op_s;
    logic              eng_busy_s, eng_done_s;
    logic [2*XLEN-1:0] eng_acc_s, prod_s;

    state_t            state_q, state_d;
    logic              ready_q, ready_d, valid_q, valid_d, illegal_q, illegal_d, neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;
    muldiv_op_t        md_op_q, md_op_d;

    // Control decode; illegal encodings report ADD.
    always_comb begin
        ctrl_s    = ALU_ADD;
        illegal_s = 1'b0;
        case (ALUOp)
            ALUOP_MEM: ctrl_s = ALU_ADD;
            ALUOP_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: ctrl_s = ALU_SUB;
                    3'b100, 3'b101: ctrl_s = ALU_SLT;
                    3'b110, 3'b111: ctrl_s = ALU_SLTU;
                    default:        illegal_s = 1'b1;
                endcase
            end
            ALUOP_RTYPE: begin
                if (op == OP_RTYPE && funct7 == F7_MULDIV) begin
                    ctrl_s = ALU_MULDIV;
                end else if (op == OP_RTYPE && funct7 != 7'b0000000 &&
                             !(funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    illegal_s = 1'b1;
                end else begin
                    case (funct3)
                        3'b000:  ctrl_s = (op[5] & funct7[5]) ? ALU_SUB : ALU_ADD;
                        3'b001:  ctrl_s = ALU_SLL;
                        3'b010:  ctrl_s = ALU_SLT;
                        3'b011:  ctrl_s = ALU_SLTU;
                        3'b100:  ctrl_s = ALU_XOR;
                        3'b101:  ctrl_s = funct7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  ctrl_s = ALU_OR;
                        default: ctrl_s = ALU_AND;
                    endcase
                end
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // Single-cycle ALU, divide corner cases and operand magnitudes for the engine.
    always_comb begin
        shamt_s = b_i[SW-1:0];
        case (ctrl_s)
            ALU_ADD:  alu_res_s = a_i + b_i;
            ALU_SUB:  alu_res_s = a_i - b_i;
            ALU_AND:  alu_res_s = a_i & b_i;
            ALU_OR:   alu_res_s = a_i | b_i;
            ALU_XOR:  alu_res_s = a_i ^ b_i;
            ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, a_i < b_i};
            ALU_SLL:  alu_res_s = a_i << shamt_s;
            ALU_SRL:  alu_res_s = a_i >> shamt_s;
            ALU_SRA:  alu_res_s = $unsigned($signed(a_i) >>> shamt_s);
            default:  alu_res_s = {XLEN{1'b0}};
        endcase

        md_op_s = muldiv_op_t'(funct3);
        case (md_op_s)
            MD_MULH, MD_DIV, MD_REM: begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
            MD_MULHSU:               begin a_sgn_s = 1'b1; b_sgn_s = 1'b0; end
            default:                 begin a_sgn_s = 1'b0; b_sgn_s = 1'b0; end
        endcase
        is_div_s   = funct3[2];
        is_rem_s   = funct3[2] & funct3[1];
        div_zero_s = (b_i == {XLEN{1'b0}});
        div_ovf_s  = (md_op_s == MD_DIV || md_op_s == MD_REM) && a_i == SMIN && b_i == ONES;
        if (div_zero_s) begin
            spec_res_s = is_rem_s ? a_i : ONES;
        end else begin
            spec_res_s = is_rem_s ? {XLEN{1'b0}} : a_i;
        end
        iter_s  = (ctrl_s == ALU_MULDIV) && !(is_div_s && (div_zero_s || div_ovf_s));
        a_neg_s = a_sgn_s & a_i[XLEN-1];
        b_neg_s = b_sgn_s & b_i[XLEN-1];
        neg_s   = is_rem_s ? a_neg_s : (a_neg_s ^ b_neg_s);
        a_mag_s = a_neg_s ? (~a_i + {{(XLEN-1){1'b0}}, 1'b1}) : a_i;
        b_mag_s = b_neg_s ? (~b_i + {{(XLEN-1){1'b0}}, 1'b1}) : b_i;
    end

    muldiv_iter #(.XLEN(XLEN)) u_engine (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_s),
        .is_div_i (is_div_s),
        .a_i      (a_mag_s),
        .b_i      (b_mag_s),
        .busy_o   (eng_busy_s),
        .done_o   (eng_done_s),
        .acc_o    (eng_acc_s)
    );

    // Sign fix-up of the final engine step: products negate across the full width,
    // quotient and remainder negate within their own half.
    always_comb begin
        prod_s = neg_q ? (~eng_acc_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : eng_acc_s;
        case (md_op_q)
            MD_MUL:                      fix_res_s = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res_s = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             fix_res_s = neg_q ? (~eng_acc_s[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1})
                                                           : eng_acc_s[XLEN-1:0];
            default:                     fix_res_s = neg_q ? (~eng_acc_s[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1})
                                                           : eng_acc_s[2*XLEN-1:XLEN];
        endcase
    end

    // FSM next state: accept in IDLE/DONE, complete when the engine finishes its last step.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        illegal_d = illegal_q;
        md_op_d   = md_op_q;
        neg_d     = neg_q;
        start_s   = 1'b0;
        accept_s  = valid_i & ready_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept_s && iter_s) begin
                    start_s = 1'b1;
                    md_op_d = md_op_s;
                    neg_d   = neg_s;
                    state_d = is_div_s ? DIV : MUL;
                end else if (accept_s) begin
                    valid_d   = 1'b1;
                    illegal_d = illegal_s;
                    if (illegal_s) begin
                        result_d = {XLEN{1'b0}};
                    end else begin
                        result_d = (ctrl_s == ALU_MULDIV) ? spec_res_s : alu_res_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL, DIV: begin
                if (eng_busy_s && eng_done_s) begin
                    result_d  = fix_res_s;
                    valid_d   = 1'b1;
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE) || (state_d == DONE);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            result_q  <= {XLEN{1'b0}};
            md_op_q   <= MD_MUL;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            result_q  <= result_d;
            md_op_q   <= md_op_d;
            neg_q     <= neg_d;
        end
    end

    assign alu_control_o = ctrl_s;
    assign ready_o       = ready_q;
    assign valid_o       = valid_q;
    assign illegal_o     = illegal_q;
    assign result_o      = result_q;

endmodule

// File: tb/tb_alu_decoder_mc.sv
// Directed bench for alu_decoder_mc: expected results queued at issue, popped on valid_o.
module tb_alu_decoder_mc;

    localparam int XLEN = 32;
    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] I_OP  = 7'b0010011;
    localparam logic [6:0] F_0   = 7'b0000000;
    localparam logic [6:0] F_ALT = 7'b0100000;
    localparam logic [6:0] F_MD  = 7'b0000001;

    logic            clk = 1'b0;
    logic            reset, valid_i, ready_o, valid_o, illegal_o;
    logic [6:0]      op, funct7;
    logic [2:0]      funct3;
    logic [1:0]      ALUOp;
    logic [XLEN-1:0] a_i, b_i, result_o;
    logic [3:0]      alu_control_o;

    logic [XLEN:0]   exp_q[$];
    int              n_checks = 0;
    int              n_errors = 0;
    int              last_rdy_low;
    int              pulses;

    always #5 clk = ~clk;

    alu_decoder_mc #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .op            (op),
        .funct3        (funct3),
        .funct7        (funct7),
        .ALUOp         (ALUOp),
        .a_i           (a_i),
        .b_i           (b_i),
        .alu_control_o (alu_control_o),
        .result_o      (result_o),
        .valid_o       (valid_o),
        .illegal_o     (illegal_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one op in the current cycle, check the combinational decode, queue the result.
    task automatic issue(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [1:0] aop,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [3:0] exp_ctrl, input logic [XLEN-1:0] exp_res,
                         input logic exp_ill, input bit push);
        op = o; funct3 = f3; funct7 = f7; ALUOp = aop; a_i = a; b_i = b; valid_i = 1'b1;
        #1;
        chk({tag, " ctrl"}, {60'd0, alu_control_o}, {60'd0, exp_ctrl});
        if (push) exp_q.push_back({exp_ill, exp_res});
    endtask

    // Wait (bounded) for valid_o, then check latency and pop/compare the scoreboard.
    task automatic wait_valid(input string tag, input int exp_lat);
        int cyc;
        logic [XLEN:0] e;
        cyc = 0;
        last_rdy_low = 0;
        do begin
            @(posedge clk); #1;
            valid_i = 1'b0;
            cyc++;
            if (!ready_o) last_rdy_low++;
        end while (!valid_o && cyc < 60);
        chk({tag, " valid"}, {63'd0, valid_o}, 64'd1);
        chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, " result"}, {32'd0, result_o}, {32'd0, e[XLEN-1:0]});
            chk({tag, " illegal"}, {63'd0, illegal_o}, {63'd0, e[XLEN]});
        end else begin
            chk({tag, " scoreboard empty"}, 64'd1, 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1; valid_i = 1'b0; op = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        ALUOp = 2'd0; a_i = 32'd0; b_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset result", {32'd0, result_o}, 64'd0);
        chk("reset valid", {63'd0, valid_o}, 64'd0);
        chk("reset illegal", {63'd0, illegal_o}, 64'd0);
        chk("reset ready", {63'd0, ready_o}, 64'd1);

        // Single-cycle ops, issued back to back.
        issue("sub", R_OP, 3'b000, F_ALT, 2'b10, 32'd5, 32'd7, 4'b0001, 32'hFFFFFFFE, 1'b0, 1'b1);
        wait_valid("sub", 1);
        chk("sub ready", {63'd0, ready_o}, 64'd1);
        issue("addi", I_OP, 3'b000, F_ALT, 2'b10, 32'd5, 32'd7, 4'b0000, 32'd12, 1'b0, 1'b1);
        wait_valid("addi", 1);
        issue("sra", R_OP, 3'b101, F_ALT, 2'b10, 32'h80000000, 32'h24, 4'b1001, 32'hF8000000, 1'b0, 1'b1);
        wait_valid("sra", 1);
        issue("srl", R_OP, 3'b101, F_0, 2'b10, 32'h80000000, 32'h24, 4'b1000, 32'h08000000, 1'b0, 1'b1);
        wait_valid("srl", 1);
        issue("sll", R_OP, 3'b001, F_0, 2'b10, 32'd1, 32'h21, 4'b0111, 32'd2, 1'b0, 1'b1);
        wait_valid("sll", 1);
        issue("br sltu", R_OP, 3'b110, F_0, 2'b01, 32'd1, 32'hFFFFFFFF, 4'b0110, 32'd1, 1'b0, 1'b1);
        wait_valid("br sltu", 1);
        issue("br slt", R_OP, 3'b100, F_0, 2'b01, 32'd1, 32'hFFFFFFFF, 4'b0101, 32'd0, 1'b0, 1'b1);
        wait_valid("br slt", 1);
        issue("br illegal", R_OP, 3'b010, F_0, 2'b01, 32'd1, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b1, 1'b1);
        wait_valid("br illegal", 1);
        issue("aluop11", R_OP, 3'b000, F_0, 2'b11, 32'd9, 32'd9, 4'b0000, 32'd0, 1'b1, 1'b1);
        wait_valid("aluop11", 1);
        issue("bad f7", R_OP, 3'b001, F_ALT, 2'b10, 32'd9, 32'd9, 4'b0000, 32'd0, 1'b1, 1'b1);
        wait_valid("bad f7", 1);
        issue("mem add", R_OP, 3'b010, F_0, 2'b00, 32'd40, 32'd2, 4'b0000, 32'd42, 1'b0, 1'b1);
        wait_valid("mem add", 1);

        // Iterative multiplies.
        issue("mulh", R_OP, 3'b001, F_MD, 2'b10, 32'hFFFFFFFF, 32'd3, 4'b1111, 32'hFFFFFFFF, 1'b0, 1'b1);
        wait_valid("mulh", 33);
        chk("mulh ready low cycles", 64'(last_rdy_low), 64'd32);
        issue("mul", R_OP, 3'b000, F_MD, 2'b10, 32'hFFFFFFFF, 32'd3, 4'b1111, 32'hFFFFFFFD, 1'b0, 1'b1);
        wait_valid("mul", 33);
        issue("mulhsu", R_OP, 3'b010, F_MD, 2'b10, 32'hFFFFFFFF, 32'd3, 4'b1111, 32'hFFFFFFFF, 1'b0, 1'b1);
        wait_valid("mulhsu", 33);
        issue("mulhu", R_OP, 3'b011, F_MD, 2'b10, 32'hFFFFFFFF, 32'd3, 4'b1111, 32'd2, 1'b0, 1'b1);
        wait_valid("mulhu", 33);

        // Divide special cases complete in one cycle.
        issue("div0", R_OP, 3'b100, F_MD, 2'b10, 32'd7, 32'd0, 4'b1111, 32'hFFFFFFFF, 1'b0, 1'b1);
        wait_valid("div0", 1);
        issue("rem0", R_OP, 3'b110, F_MD, 2'b10, 32'd7, 32'd0, 4'b1111, 32'd7, 1'b0, 1'b1);
        wait_valid("rem0", 1);
        issue("div ovf", R_OP, 3'b100, F_MD, 2'b10, 32'h80000000, 32'hFFFFFFFF, 4'b1111, 32'h80000000, 1'b0, 1'b1);
        wait_valid("div ovf", 1);
        issue("rem ovf", R_OP, 3'b110, F_MD, 2'b10, 32'h80000000, 32'hFFFFFFFF, 4'b1111, 32'd0, 1'b0, 1'b1);
        wait_valid("rem ovf", 1);

        // Iterative divides; an ADD is accepted in the DONE cycle of DIVU.
        issue("divu", R_OP, 3'b101, F_MD, 2'b10, 32'd100, 32'd7, 4'b1111, 32'd14, 1'b0, 1'b1);
        wait_valid("divu", 33);
        chk("done ready", {63'd0, ready_o}, 64'd1);
        issue("add in done", R_OP, 3'b000, F_0, 2'b00, 32'd3, 32'd4, 4'b0000, 32'd7, 1'b0, 1'b1);
        wait_valid("add in done", 1);
        issue("remu", R_OP, 3'b111, F_MD, 2'b10, 32'd100, 32'd7, 4'b1111, 32'd2, 1'b0, 1'b1);
        wait_valid("remu", 33);
        issue("div neg", R_OP, 3'b100, F_MD, 2'b10, 32'hFFFFFF9C, 32'd7, 4'b1111, 32'hFFFFFFF2, 1'b0, 1'b1);
        wait_valid("div neg", 33);
        issue("rem neg", R_OP, 3'b110, F_MD, 2'b10, 32'hFFFFFF9C, 32'd7, 4'b1111, 32'hFFFFFFFE, 1'b0, 1'b1);
        wait_valid("rem neg", 33);

        // Reset in the middle of a DIV aborts it without any valid_o.
        issue("div abort", R_OP, 3'b100, F_MD, 2'b10, 32'd100, 32'd7, 4'b1111, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("busy at T+10", {63'd0, ready_o}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort ready", {63'd0, ready_o}, 64'd1);
        chk("abort valid", {63'd0, valid_o}, 64'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_o) pulses++;
        end
        chk("no stray valid", 64'(pulses), 64'd0);
        issue("after abort", R_OP, 3'b111, F_0, 2'b10, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0010, 32'h00F000F0, 1'b0, 1'b1);
        wait_valid("after abort", 1);
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
